// File: rtl/lc3_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : lc3_control_fsm
// Description : Moore sequencing controller for the LC-3 datapath. Drives all
//               load enables, bus gates, mux selects and SRAM strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_control_fsm (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    input  logic       Mem_Ready,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [3:0] c_OP_BR    = 4'b0000;
    localparam logic [3:0] c_OP_ADD   = 4'b0001;
    localparam logic [3:0] c_OP_JSR   = 4'b0100;
    localparam logic [3:0] c_OP_AND   = 4'b0101;
    localparam logic [3:0] c_OP_LDR   = 4'b0110;
    localparam logic [3:0] c_OP_STR   = 4'b0111;
    localparam logic [3:0] c_OP_NOT   = 4'b1001;
    localparam logic [3:0] c_OP_JMP   = 4'b1100;
    localparam logic [3:0] c_OP_PAUSE = 4'b1101;

    localparam logic [1:0] c_PCMUX_INC   = 2'b00;
    localparam logic [1:0] c_PCMUX_BUS   = 2'b01;
    localparam logic [1:0] c_PCMUX_ADDER = 2'b10;

    localparam logic [1:0] c_ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] c_ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] c_ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] c_ALUK_ADD  = 2'b00;
    localparam logic [1:0] c_ALUK_AND  = 2'b01;
    localparam logic [1:0] c_ALUK_NOT  = 2'b10;
    localparam logic [1:0] c_ALUK_PASS = 2'b11;

    typedef enum logic [4:0] {
        ST_HALTED = 5'd0,
        ST_F1     = 5'd1,
        ST_F2     = 5'd2,
        ST_F3     = 5'd3,
        ST_DECODE = 5'd4,
        ST_ADD    = 5'd5,
        ST_AND    = 5'd6,
        ST_NOT    = 5'd7,
        ST_BR0    = 5'd8,
        ST_BR1    = 5'd9,
        ST_JMP    = 5'd10,
        ST_JSR0   = 5'd11,
        ST_JSR1   = 5'd12,
        ST_LDR0   = 5'd13,
        ST_LDR1   = 5'd14,
        ST_LDR2   = 5'd15,
        ST_STR0   = 5'd16,
        ST_STR1   = 5'd17,
        ST_STR2   = 5'd18,
        ST_PAUSE0 = 5'd19,
        ST_PAUSE1 = 5'd20
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Outputs decode from r_state only, so the async reset into HALTED
    // clears every strobe and enable in the same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_HALTED;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        LD_MAR       = 1'b0;
        LD_MDR       = 1'b0;
        LD_IR        = 1'b0;
        LD_BEN       = 1'b0;
        LD_CC        = 1'b0;
        LD_REG       = 1'b0;
        LD_PC        = 1'b0;
        LD_LED       = 1'b0;
        GatePC       = 1'b0;
        GateMDR      = 1'b0;
        GateALU      = 1'b0;
        GateMARMUX   = 1'b0;
        PCMUX        = c_PCMUX_INC;
        DRMUX        = 1'b0;
        SR1MUX       = 1'b0;
        SR2MUX       = 1'b0;
        ADDR1MUX     = 1'b0;
        ADDR2MUX     = 2'b00;
        ALUK         = c_ALUK_ADD;
        Mem_OE       = 1'b0;
        Mem_WE       = 1'b0;

        case (r_state)
            ST_HALTED: begin
                if (Run) w_next_state = ST_F1;
            end
            ST_F1: begin
                GatePC       = 1'b1;
                LD_MAR       = 1'b1;
                PCMUX        = c_PCMUX_INC;
                LD_PC        = 1'b1;
                w_next_state = ST_F2;
            end
            ST_F2: begin
                Mem_OE = 1'b1;
                LD_MDR = 1'b1;
                if (Mem_Ready) w_next_state = ST_F3;
            end
            ST_F3: begin
                GateMDR      = 1'b1;
                LD_IR        = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    c_OP_ADD:   w_next_state = ST_ADD;
                    c_OP_AND:   w_next_state = ST_AND;
                    c_OP_NOT:   w_next_state = ST_NOT;
                    c_OP_BR:    w_next_state = ST_BR0;
                    c_OP_JMP:   w_next_state = ST_JMP;
                    c_OP_JSR:   w_next_state = ST_JSR0;
                    c_OP_LDR:   w_next_state = ST_LDR0;
                    c_OP_STR:   w_next_state = ST_STR0;
                    c_OP_PAUSE: w_next_state = ST_PAUSE0;
                    default:    w_next_state = ST_F1;
                endcase
            end
            ST_ADD, ST_AND, ST_NOT: begin
                SR1MUX       = 1'b1;
                SR2MUX       = IR_5;
                GateALU      = 1'b1;
                LD_REG       = 1'b1;
                LD_CC        = 1'b1;
                DRMUX        = 1'b0;
                ALUK         = (r_state == ST_ADD) ? c_ALUK_ADD :
                               (r_state == ST_AND) ? c_ALUK_AND : c_ALUK_NOT;
                w_next_state = ST_F1;
            end
            ST_BR0: begin
                w_next_state = BEN ? ST_BR1 : ST_F1;
            end
            ST_BR1: begin
                ADDR1MUX     = 1'b0;
                ADDR2MUX     = c_ADDR2_OFF9;
                PCMUX        = c_PCMUX_ADDER;
                LD_PC        = 1'b1;
                w_next_state = ST_F1;
            end
            ST_JMP: begin
                SR1MUX       = 1'b1;
                ALUK         = c_ALUK_PASS;
                GateALU      = 1'b1;
                PCMUX        = c_PCMUX_BUS;
                LD_PC        = 1'b1;
                w_next_state = ST_F1;
            end
            ST_JSR0: begin
                GatePC       = 1'b1;
                DRMUX        = 1'b1;
                LD_REG       = 1'b1;
                w_next_state = ST_JSR1;
            end
            ST_JSR1: begin
                LD_PC = 1'b1;
                // JSR takes the PC-relative adder path; JSRR routes BaseR over the bus.
                if (IR_11) begin
                    ADDR1MUX = 1'b0;
                    ADDR2MUX = c_ADDR2_OFF11;
                    PCMUX    = c_PCMUX_ADDER;
                end else begin
                    SR1MUX   = 1'b1;
                    ALUK     = c_ALUK_PASS;
                    GateALU  = 1'b1;
                    PCMUX    = c_PCMUX_BUS;
                end
                w_next_state = ST_F1;
            end
            ST_LDR0, ST_STR0: begin
                SR1MUX       = 1'b1;
                ADDR1MUX     = 1'b1;
                ADDR2MUX     = c_ADDR2_OFF6;
                GateMARMUX   = 1'b1;
                LD_MAR       = 1'b1;
                w_next_state = (r_state == ST_LDR0) ? ST_LDR1 : ST_STR1;
            end
            ST_LDR1: begin
                Mem_OE = 1'b1;
                LD_MDR = 1'b1;
                if (Mem_Ready) w_next_state = ST_LDR2;
            end
            ST_LDR2: begin
                GateMDR      = 1'b1;
                DRMUX        = 1'b0;
                LD_REG       = 1'b1;
                LD_CC        = 1'b1;
                w_next_state = ST_F1;
            end
            ST_STR1: begin
                SR1MUX       = 1'b0;
                ALUK         = c_ALUK_PASS;
                GateALU      = 1'b1;
                LD_MDR       = 1'b1;
                w_next_state = ST_STR2;
            end
            ST_STR2: begin
                Mem_WE = 1'b1;
                if (Mem_Ready) w_next_state = ST_F1;
            end
            ST_PAUSE0: begin
                LD_LED = 1'b1;
                if (Continue) w_next_state = ST_PAUSE1;
            end
            ST_PAUSE1: begin
                if (!Continue) w_next_state = ST_F1;
            end
            default: begin
                w_next_state = ST_HALTED;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_control_fsm
// Description : Table-driven bench for lc3_control_fsm with reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_control_fsm;

    logic       Clk = 1'b0;
    logic       Reset_n, Run, Continue, IR_5, IR_11, BEN, Mem_Ready;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

    always #5 Clk = ~Clk;

    lc3_control_fsm dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Mem_Ready(Mem_Ready),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    logic [23:0] w_out;
    assign w_out = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                    GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
                    DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    localparam logic [23:0] M_LD_MAR    = 24'h800000;
    localparam logic [23:0] M_LD_MDR    = 24'h400000;
    localparam logic [23:0] M_LD_IR     = 24'h200000;
    localparam logic [23:0] M_LD_BEN    = 24'h100000;
    localparam logic [23:0] M_LD_CC     = 24'h080000;
    localparam logic [23:0] M_LD_REG    = 24'h040000;
    localparam logic [23:0] M_LD_PC     = 24'h020000;
    localparam logic [23:0] M_LD_LED    = 24'h010000;
    localparam logic [23:0] M_GPC       = 24'h008000;
    localparam logic [23:0] M_GMDR      = 24'h004000;
    localparam logic [23:0] M_GALU      = 24'h002000;
    localparam logic [23:0] M_GMARMUX   = 24'h001000;
    localparam logic [23:0] M_PC_BUS    = 24'h000400;
    localparam logic [23:0] M_PC_ADD    = 24'h000800;
    localparam logic [23:0] M_DRMUX     = 24'h000200;
    localparam logic [23:0] M_SR1       = 24'h000100;
    localparam logic [23:0] M_SR2       = 24'h000080;
    localparam logic [23:0] M_A1        = 24'h000040;
    localparam logic [23:0] M_A2_6      = 24'h000010;
    localparam logic [23:0] M_A2_9      = 24'h000020;
    localparam logic [23:0] M_A2_11     = 24'h000030;
    localparam logic [23:0] M_ALU_AND   = 24'h000004;
    localparam logic [23:0] M_ALU_NOT   = 24'h000008;
    localparam logic [23:0] M_ALU_PASS  = 24'h00000C;
    localparam logic [23:0] M_OE        = 24'h000002;
    localparam logic [23:0] M_WE        = 24'h000001;

    localparam logic [23:0] E_ZERO   = 24'h000000;
    localparam logic [23:0] E_F1     = M_GPC | M_LD_MAR | M_LD_PC;
    localparam logic [23:0] E_F2     = M_OE | M_LD_MDR;
    localparam logic [23:0] E_F3     = M_GMDR | M_LD_IR;
    localparam logic [23:0] E_DEC    = M_LD_BEN;
    localparam logic [23:0] E_ALU    = M_SR1 | M_GALU | M_LD_REG | M_LD_CC;
    localparam logic [23:0] E_BR1    = M_A2_9 | M_PC_ADD | M_LD_PC;
    localparam logic [23:0] E_JMP    = M_SR1 | M_ALU_PASS | M_GALU | M_PC_BUS | M_LD_PC;
    localparam logic [23:0] E_JSR0   = M_GPC | M_DRMUX | M_LD_REG;
    localparam logic [23:0] E_JSR1A  = M_LD_PC | M_A2_11 | M_PC_ADD;
    localparam logic [23:0] E_JSR1B  = M_LD_PC | M_SR1 | M_ALU_PASS | M_GALU | M_PC_BUS;
    localparam logic [23:0] E_LDR0   = M_SR1 | M_A1 | M_A2_6 | M_GMARMUX | M_LD_MAR;
    localparam logic [23:0] E_LDR1   = M_OE | M_LD_MDR;
    localparam logic [23:0] E_LDR2   = M_GMDR | M_LD_REG | M_LD_CC;
    localparam logic [23:0] E_STR1   = M_ALU_PASS | M_GALU | M_LD_MDR;
    localparam logic [23:0] E_STR2   = M_WE;
    localparam logic [23:0] E_PAUSE0 = M_LD_LED;

    typedef struct {
        logic        run;
        logic        cont;
        logic [3:0]  op;
        logic        ir5;
        logic        ir11;
        logic        ben;
        logic        mr;
        logic [23:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mkv(input logic run, input logic cont, input logic [3:0] op,
                                 input logic ir5, input logic ir11, input logic ben,
                                 input logic mr, input logic [23:0] exp, input string tag);
        vec_t v;
        v.run = run; v.cont = cont; v.op = op; v.ir5 = ir5; v.ir11 = ir11;
        v.ben = ben; v.mr = mr; v.exp = exp; v.tag = tag;
        return v;
    endfunction

    task automatic add(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben,
                       input logic mr, input logic cont, input logic [23:0] exp, input string tag);
        vecs.push_back(mkv(1'b0, cont, op, ir5, ir11, ben, mr, exp, tag));
    endtask

    task automatic fetch(input logic [3:0] op, input logic ir5, input logic ir11,
                         input logic ben, input int f2_waits);
        add(op, ir5, ir11, ben, 1'b1, 1'b0, E_F1, "F1");
        for (int i = 0; i < f2_waits; i++) add(op, ir5, ir11, ben, 1'b0, 1'b0, E_F2, "F2_wait");
        add(op, ir5, ir11, ben, 1'b1, 1'b0, E_F2, "F2");
        add(op, ir5, ir11, ben, 1'b1, 1'b0, E_F3, "F3");
        add(op, ir5, ir11, ben, 1'b1, 1'b0, E_DEC, "DECODE");
    endtask

    task automatic check(input string tag, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h at %0t", tag, act, exp, $time);
        end
    endtask

    // Inputs applied just after a rising edge; outputs checked on the falling edge.
    task automatic step(input vec_t v);
        Run = v.run; Continue = v.cont; Opcode = v.op; IR_5 = v.ir5;
        IR_11 = v.ir11; BEN = v.ben; Mem_Ready = v.mr;
        @(negedge Clk);
        check(v.tag, w_out, v.exp);
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        n_checks++;
        if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1 || (Mem_OE && Mem_WE)) begin
            n_fail++;
            $display("FAIL bus_exclusive: gates %b oe %b we %b at %0t",
                     {GatePC, GateMDR, GateALU, GateMARMUX}, Mem_OE, Mem_WE, $time);
        end
    end

    initial begin
        Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'h0;
        IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0; Mem_Ready = 1'b0;

        vecs.push_back(mkv(1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, E_ZERO, "HALT_run0"));
        vecs.push_back(mkv(1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, E_ZERO, "HALT_run0b"));
        vecs.push_back(mkv(1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, E_ZERO, "HALT_run1"));
        fetch(4'b0001, 1'b1, 1'b0, 1'b0, 0);
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_ALU | M_SR2, "ADD_imm");
        fetch(4'b0101, 1'b0, 1'b0, 1'b0, 1);
        add(4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_ALU | M_ALU_AND, "AND_reg");
        fetch(4'b1001, 1'b1, 1'b0, 1'b0, 0);
        add(4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_ALU | M_SR2 | M_ALU_NOT, "NOT");
        fetch(4'b0000, 1'b0, 1'b0, 1'b1, 0);
        add(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_ZERO, "BR0_taken");
        add(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_BR1, "BR1");
        fetch(4'b0000, 1'b0, 1'b0, 1'b0, 0);
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_ZERO, "BR0_not_taken");
        fetch(4'b1100, 1'b0, 1'b0, 1'b0, 0);
        add(4'b1100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_JMP, "JMP");
        fetch(4'b0100, 1'b0, 1'b1, 1'b0, 0);
        add(4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_JSR0, "JSR0");
        add(4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_JSR1A, "JSR1_jsr");
        fetch(4'b0100, 1'b0, 1'b0, 1'b0, 0);
        add(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_JSR0, "JSRR0");
        add(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_JSR1B, "JSR1_jsrr");
        fetch(4'b0110, 1'b0, 1'b0, 1'b0, 0);
        add(4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_LDR0, "LDR0");
        for (int i = 0; i < 3; i++) add(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_LDR1, "LDR1_wait");
        add(4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_LDR1, "LDR1");
        add(4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_LDR2, "LDR2");
        fetch(4'b0111, 1'b0, 1'b0, 1'b0, 0);
        add(4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_LDR0, "STR0");
        add(4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_STR1, "STR1");
        add(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_STR2, "STR2_wait");
        add(4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_STR2, "STR2");
        fetch(4'b1111, 1'b0, 1'b0, 1'b0, 0);
        fetch(4'b1101, 1'b0, 1'b0, 1'b0, 0);
        add(4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_PAUSE0, "PAUSE0_hold");
        add(4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_PAUSE0, "PAUSE0_hold2");
        add(4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_PAUSE0, "PAUSE0_go");
        add(4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_ZERO, "PAUSE1_hold");
        add(4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_ZERO, "PAUSE1_hold2");
        add(4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_ZERO, "PAUSE1_go");

        #2;
        check("reset_asserted", w_out, E_ZERO);
        @(posedge Clk);
        #1;
        check("reset_edge", w_out, E_ZERO);
        Reset_n = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // Async reset in the middle of an instruction fetch read.
        step(mkv(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, E_F1, "A_F1"));
        step(mkv(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, E_F2, "A_F2"));
        check("A_F2_oe", w_out, E_F2);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_mid_F2", w_out, E_ZERO);
        @(posedge Clk);
        #1;
        check("rst_mid_F2_edge", w_out, E_ZERO);
        Reset_n = 1'b1;
        step(mkv(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, E_ZERO, "B_HALT_run0"));
        step(mkv(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, E_ZERO, "B_HALT_run0b"));
        step(mkv(1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, E_ZERO, "B_HALT_run1"));
        step(mkv(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, E_F1, "B_F1"));
        step(mkv(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, E_F2, "B_F2"));
        step(mkv(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, E_F3, "B_F3"));
        step(mkv(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, E_DEC, "B_DEC"));
        step(mkv(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, E_LDR0, "B_STR0"));
        step(mkv(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, E_STR1, "B_STR1"));
        check("B_STR2_we", w_out, E_STR2);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_mid_STR2", w_out, E_ZERO);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        step(mkv(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, E_ZERO, "C_HALT_run1"));
        step(mkv(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, E_F1, "C_F1_release"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lc3_control_fsm.md
# lc3_control_fsm

Sequencing controller for the 16-bit LC-3 datapath. Walks each instruction through fetch, decode and execute, and drives every load enable, bus gate and mux select. This includes ADDR1MUX/ADDR2MUX for the address adder, so PC-relative and base+offset addresses are formed in the right cycle. It handshakes with the SRAM wrapper for every memory access. It sits beside the datapath in the top-level computer; it has no data path of its own.

## Interface
- No parameters; encodings below are fixed.
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  leaves HALTED when high.
- Continue  in  1  pause-release handshake.
- Opcode  in  4  IR[15:12].
- IR_5  in  1  ADD/AND immediate select.
- IR_11  in  1  JSR (1) vs JSRR (0).
- BEN  in  1  registered branch enable from datapath.
- Mem_Ready  in  1  memory access complete, sampled each cycle.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers.
- PCMUX  out  2  00 PC+1, 01 bus, 10 adder.
- DRMUX  out  1  0 IR[11:9], 1 R7.
- SR1MUX  out  1  0 IR[11:9], 1 IR[8:6].
- SR2MUX  out  1  0 register, 1 sext IR[4:0].
- ADDR1MUX  out  1  0 PC, 1 SR1.
- ADDR2MUX  out  2  00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0].
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A.
- Mem_OE, Mem_WE  out  1 each  memory read/write strobes.

## Operation
- Moore FSM. All outputs decode from the current state only. Any output not listed for a state is 0.
- HALTED: stays here while Run=0; goes to F1 when Run=1.
- F1: GatePC, LD_MAR, PCMUX=00, LD_PC. Next state F2.
- F2: Mem_OE, LD_MDR. Stays while Mem_Ready=0; goes to F3 on Mem_Ready=1.
- F3: GateMDR, LD_IR. Next state DECODE.
- DECODE: LD_BEN. Dispatches on Opcode:
  - 0001 → ADD
  - 0101 → AND
  - 1001 → NOT
  - 0000 → BR0
  - 1100 → JMP
  - 0100 → JSR0
  - 0110 → LDR0
  - 0111 → STR0
  - 1101 → PAUSE0
  - any other → F1 (treated as NOP)
- ADD/AND/NOT: SR1MUX=1, SR2MUX=IR_5, ALUK=00/01/10, GateALU, LD_REG, LD_CC, DRMUX=0. Next state F1.
- BR0: goes to BR1 if BEN=1, else F1.
- BR1: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC. Next state F1.
- JMP: SR1MUX=1, ALUK=11, GateALU, PCMUX=01, LD_PC. Next state F1.
- JSR0: GatePC, DRMUX=1, LD_REG (R7←PC). Next state JSR1.
- JSR1: LD_PC with:
  - IR_11=1: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10.
  - IR_11=0: SR1MUX=1, ALUK=11, GateALU, PCMUX=01.
  - Next state F1.
- LDR0: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR. Next state LDR1.
- LDR1: Mem_OE, LD_MDR. Waits on Mem_Ready as in F2; then LDR2.
- LDR2: GateMDR, DRMUX=0, LD_REG, LD_CC. Next state F1.
- STR0: as LDR0. Next state STR1.
- STR1: SR1MUX=0, ALUK=11, GateALU, LD_MDR. Next state STR2.
- STR2: Mem_WE. Waits on Mem_Ready; then F1.
- PAUSE0: LD_LED. Stays while Continue=0; goes to PAUSE1 on Continue=1.
- PAUSE1: stays while Continue=1; goes to F1 on Continue=0. One instruction per button press.
- Invariant: at most one Gate* high in any cycle. Mem_OE and Mem_WE are never high together.

## Timing
- Reset_n low forces HALTED immediately, without waiting for a clock edge. All outputs are 0 while reset is asserted and on release.
- Reset mid-access (F2/LDR1/STR2) drops Mem_OE/Mem_WE in the same cycle. No partial register load may follow.
- Release: the first transition out of HALTED occurs on the first rising edge with Reset_n=1 and Run=1.
- Minimum cycle counts with Mem_Ready already high:
  - Fetch: 3 cycles (F1-F3) + DECODE, 4 cycles total before execute.
  - ALU ops: 5 cycles.
  - BR not taken: 5 cycles; taken: 6.
  - JMP: 5 cycles.
  - JSR: 6 cycles.
  - LDR: 7 cycles.
  - STR: 7 cycles.
- Each cycle of Mem_Ready=0 adds exactly one cycle in the waiting state. Strobes stay asserted throughout the wait.
- Mem_Ready high outside a memory state is ignored.
- Run is ignored outside HALTED. Continue is ignored outside PAUSE0/PAUSE1.

## Test plan
- Reset, then Run=1, Opcode=0001, IR_5=1, Mem_Ready=1 → state sequence F1,F2,F3,DECODE,ADD,F1. In the ADD cycle: GateALU=1, LD_REG=1, LD_CC=1, SR2MUX=1, ALUK=00.
- Opcode=0000 with BEN=1, then with BEN=0 → taken path has a BR1 cycle with ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC=1. Not-taken path returns to F1 after BR0 with LD_PC never asserted.
- Opcode=0110, Mem_Ready held low 3 cycles in LDR1 → LDR0 shows ADDR1MUX=1, ADDR2MUX=01, LD_MAR=1. Mem_OE is high for 4 consecutive cycles. LDR2 asserts GateMDR and LD_REG once.
- Opcode=0100 with IR_11=1, then with IR_11=0 → JSR0 has DRMUX=1, GatePC=1. JSR1 shows ADDR2MUX=11, PCMUX=10 for JSR and PCMUX=01, GateALU=1 for JSRR.
- Opcode=1101; Continue pulses 0→1→0 → LD_LED high only in PAUSE0. FSM holds in PAUSE0 and PAUSE1 until each edge, then returns to F1.
- Assert Reset_n low mid-F2 and mid-STR2 (Mem_WE=1) → all outputs 0 in the same cycle, state HALTED. Run=0 keeps it there. Throughout all scenarios, check via assertion that no two Gate* signals are ever high together.
